// File: rtl/pipe_chain.sv
`default_nettype none
// ====================================================================
// pipe_chain : elastic DEPTH-stage ready/valid register pipeline
//              with global stall and flush
// Revision   : 1.0
// ====================================================================
module pipe_chain #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             stall,
  input  logic             flush,
  output logic [CNT_W-1:0] occupancy
);

  logic [DEPTH-1:0] r_v;
  logic [WIDTH-1:0] r_d [DEPTH];
  logic [DEPTH:0]   w_rdy;
  logic [DEPTH-1:0] w_up_v;
  logic [WIDTH-1:0] w_up_d [DEPTH];
  logic             w_hold;

  assign w_hold = stall | flush;

  // A stage can load when it is empty or its successor is loading too.
  always_comb begin
    w_rdy[DEPTH] = out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      w_rdy[k] = !w_hold & (!r_v[k] | w_rdy[k+1]);
    end
  end

  always_comb begin
    w_up_v[0] = in_valid;
    w_up_d[0] = in_data;
    for (int k = 1; k < DEPTH; k++) begin
      w_up_v[k] = r_v[k-1];
      w_up_d[k] = r_d[k-1];
    end
  end

  always_comb begin
    occupancy = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occupancy = occupancy + CNT_W'(r_v[k]);
    end
  end

  assign in_ready  = w_rdy[0];
  assign out_valid = r_v[DEPTH-1] & !w_hold;
  assign out_data  = r_d[DEPTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        r_d[k] <= '0;
      end
    end else if (flush) begin
      r_v <= '0;
    end else begin
      // Data registers only load on a valid word so bubbles leave payload intact.
      for (int k = 0; k < DEPTH; k++) begin
        if (w_rdy[k]) begin
          r_v[k] <= w_up_v[k];
          if (w_up_v[k]) begin
            r_d[k] <= w_up_d[k];
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_chain.sv
`default_nettype none
// tb_pipe_chain : directed scoreboard bench for a DEPTH=4 pipe_chain plus a
// randomised DEPTH=1, WIDTH=8 instance.
module tb_pipe_chain;
  localparam int A_W = 32;
  localparam int A_D = 4;
  localparam int B_W = 8;
  localparam int B_D = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           a_rst, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_stall, a_flush;
  logic [A_W-1:0] a_in_data, a_out_data;
  logic [2:0]     a_occ;

  logic           b_rst, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_stall, b_flush;
  logic [B_W-1:0] b_in_data, b_out_data;
  logic [0:0]     b_occ;

  pipe_chain #(.WIDTH(A_W), .DEPTH(A_D)) u_a (
    .clk(clk), .rst(a_rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
    .stall(a_stall), .flush(a_flush), .occupancy(a_occ)
  );

  pipe_chain #(.WIDTH(B_W), .DEPTH(B_D)) u_b (
    .clk(clk), .rst(b_rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
    .stall(b_stall), .flush(b_flush), .occupancy(b_occ)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [31:0] a_q_data [$];
  int          a_q_cyc  [$];
  int          a_lat    [$];
  logic [7:0]  b_q      [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock of instance A: score handshakes just before the edge, then advance.
  task automatic a_cycle();
    #1;
    if (!a_rst) begin
      if (a_out_valid === 1'b1 && a_out_ready) begin
        check("a_out_expected", 32'(a_q_data.size() != 0), 32'd1);
        if (a_q_data.size() != 0) begin
          check("a_out_data", a_out_data, a_q_data.pop_front());
          a_lat.push_back(cyc - a_q_cyc.pop_front());
        end
      end
      if (a_in_valid && a_in_ready === 1'b1) begin
        a_q_data.push_back(a_in_data);
        a_q_cyc.push_back(cyc);
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic a_drain(input string tag);
    int n = 0;
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    while ((a_q_data.size() != 0 || a_occ != 3'd0) && n < 40) begin
      a_cycle();
      n++;
    end
    check(tag, 32'(a_q_data.size()), 32'd0);
    check({tag, "_occ"}, 32'(a_occ), 32'd0);
  endtask

  initial begin
    a_rst = 1'b1; a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b0; a_stall = 1'b0; a_flush = 1'b0;
    b_rst = 1'b1; b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b0; b_stall = 1'b0; b_flush = 1'b0;
    a_cycle();
    a_cycle();
    a_rst = 1'b0;
    b_rst = 1'b0;
    #1;
    check("rst_in_ready",  32'(a_in_ready),  32'd1);
    check("rst_out_valid", 32'(a_out_valid), 32'd0);
    check("rst_out_data",  a_out_data,       32'd0);
    check("rst_occ",       32'(a_occ),       32'd0);
    check("rst_b_ready",   32'(b_in_ready),  32'd1);
    check("rst_b_occ",     32'(b_occ),       32'd0);

    // Streaming 0x1..0x8 with the sink always ready.
    a_lat.delete();
    a_out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      a_in_valid = 1'b1;
      a_in_data  = 32'(i);
      a_cycle();
      if (i >= 4) check("t1_occ", 32'(a_occ), 32'd4);
    end
    a_drain("t1_drain");
    check("t1_count", 32'(a_lat.size()), 32'd8);
    foreach (a_lat[j]) check("t1_latency", 32'(a_lat[j]), 32'd4);

    // Fill under backpressure, then release it.
    a_lat.delete();
    a_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_in_valid = 1'b1;
      a_in_data  = 32'hA0 + 32'(i);
      check("t2_fill_ready", 32'(a_in_ready), 32'd1);
      a_cycle();
    end
    a_in_data = 32'hA4;
    check("t2_full_occ",   32'(a_occ),      32'd4);
    check("t2_full_ready", 32'(a_in_ready), 32'd0);
    a_cycle();
    check("t2_a4_refused", 32'(a_q_data.size()), 32'd4);
    check("t2_hold_occ",   32'(a_occ),       32'd4);
    check("t2_head_valid", 32'(a_out_valid), 32'd1);
    check("t2_head_data",  a_out_data,       32'hA0);
    a_out_ready = 1'b1;
    #1;
    check("t2_release_ready", 32'(a_in_ready), 32'd1);
    a_cycle();
    check("t2_a4_taken", 32'(a_q_data.size()), 32'd4);
    check("t2_a4_tail",  a_q_data[$],          32'hA4);
    a_drain("t2_drain");
    check("t2_count", 32'(a_lat.size()), 32'd5);

    // Three-cycle stall in the middle of a stream.
    a_lat.delete();
    a_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      a_in_valid = 1'b1;
      a_in_data  = 32'h10 + 32'(i);
      a_cycle();
    end
    a_stall   = 1'b1;
    a_in_data = 32'h14;
    for (int s = 0; s < 3; s++) begin
      #1;
      check("t3_stall_ready", 32'(a_in_ready),  32'd0);
      check("t3_stall_valid", 32'(a_out_valid), 32'd0);
      check("t3_stall_occ",   32'(a_occ),       32'd4);
      a_cycle();
    end
    a_stall = 1'b0;
    for (int i = 4; i < 8; i++) begin
      a_in_data = 32'h10 + 32'(i);
      a_cycle();
    end
    a_drain("t3_drain");
    check("t3_count", 32'(a_lat.size()), 32'd8);
    foreach (a_lat[j]) check("t3_latency", 32'(a_lat[j]), (j < 4) ? 32'd7 : 32'd4);

    // Flush together with stall while three words are in flight.
    a_lat.delete();
    a_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a_in_valid = 1'b1;
      a_in_data  = 32'h30 + 32'(i);
      a_cycle();
    end
    a_in_valid = 1'b0;
    check("t4_inflight_occ", 32'(a_occ), 32'd3);
    a_flush = 1'b1;
    a_stall = 1'b1;
    #1;
    check("t4_flush_ready", 32'(a_in_ready),  32'd0);
    check("t4_flush_valid", 32'(a_out_valid), 32'd0);
    a_cycle();
    a_flush = 1'b0;
    a_stall = 1'b0;
    a_q_data.delete();
    a_q_cyc.delete();
    #1;
    check("t4_post_occ",   32'(a_occ),       32'd0);
    check("t4_post_valid", 32'(a_out_valid), 32'd0);
    a_in_valid = 1'b1;
    a_in_data  = 32'h55;
    a_cycle();
    a_drain("t4_drain");
    check("t4_count", 32'(a_lat.size()), 32'd1);
    foreach (a_lat[j]) check("t4_latency", 32'(a_lat[j]), 32'd4);

    // Synchronous reset with the pipe full and the sink ready.
    a_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      a_in_valid = 1'b1;
      a_in_data  = 32'h40 + 32'(i);
      a_cycle();
    end
    a_in_valid = 1'b0;
    check("t5_full_occ", 32'(a_occ), 32'd4);
    a_out_ready = 1'b1;
    a_rst       = 1'b1;
    a_cycle();
    a_rst = 1'b0;
    a_q_data.delete();
    a_q_cyc.delete();
    #1;
    check("t5_out_valid", 32'(a_out_valid), 32'd0);
    check("t5_out_data",  a_out_data,       32'd0);
    check("t5_occ",       32'(a_occ),       32'd0);
    check("t5_in_ready",  32'(a_in_ready),  32'd1);

    // DEPTH=1 random traffic against a queue model.
    for (int n = 0; n < 10000; n++) begin
      b_in_valid  = 1'($urandom_range(0, 1));
      b_in_data   = 8'($urandom);
      b_out_ready = ($urandom_range(0, 3) != 0);
      b_stall     = ($urandom_range(0, 7) == 0);
      #1;
      check("b_qsize",     32'(b_q.size() <= 1), 32'd1);
      check("b_occ",       32'(b_occ),       32'(b_q.size()));
      check("b_in_ready",  32'(b_in_ready),  32'(!b_stall && (b_q.size() == 0 || b_out_ready)));
      check("b_out_valid", 32'(b_out_valid), 32'((b_q.size() != 0) && !b_stall));
      if (b_out_valid && b_out_ready && b_q.size() != 0) begin
        check("b_out_data", 32'(b_out_data), 32'(b_q.pop_front()));
      end
      if (b_in_valid && b_in_ready) b_q.push_back(b_in_data);
      @(posedge clk);
      #1;
    end
    b_in_valid  = 1'b0;
    b_stall     = 1'b0;
    b_out_ready = 1'b1;
    for (int n = 0; n < 4 && b_q.size() != 0; n++) begin
      #1;
      if (b_out_valid && b_q.size() != 0) begin
        check("b_drain_data", 32'(b_out_data), 32'(b_q.pop_front()));
      end
      @(posedge clk);
      #1;
    end
    check("b_drain_empty", 32'(b_q.size()), 32'd0);
    check("b_drain_occ",   32'(b_occ),      32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
